culsans_exit_monitor: RTL and testbench
=======================================

# culsans_exit_monitor

Passive AXI/ACE monitor on the crossbar's DRAM slave port. It watches the write channels (AW, W, B) for a completed store to the test-exit mailbox, `culsans_pkg::exitAddr`, and reports the test result to the testbench or FPGA status logic. It never drives `ready`/`valid` on the bus. It tracks outstanding write bursts itself, so it stays correct under interleaved multi-core traffic.

## Interface
Parameters:
- `ExitAddr`, default `culsans_pkg::exitAddr`: 8-byte-aligned mailbox address.
- `AwDepth`, default 4: number of tracked outstanding AW bursts (power of 2, ≥2).
- `req_t`, default `culsans_pkg::req_slv_t`: monitored request struct.
- `resp_t`, default `culsans_pkg::resp_slv_t`: monitored response struct.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `axi_req_i`  in  req_t  monitored request (AW/W/B-ready used).
- `axi_resp_i`  in  resp_t  monitored response (aw_ready/w_ready/B used).
- `exit_valid_o`  out  1  sticky; test finished.
- `exit_code_o`  out  31  mailbox `data[31:1]`; valid while `exit_valid_o`.
- `exit_id_o`  out  `IdWidthSlave`  AXI ID of the exiting write.
- `exit_err_o`  out  1  sticky; the mailbox write got a non-OKAY B response.
- `overflow_o`  out  1  sticky; tracking was lost (AW FIFO full, or a second W burst arrived ahead of its AW).

## Operation
- **AW tracking**
  - On each AW handshake (`aw_valid & aw_ready`), push the entry `{id, hit}`, where `hit = (aw.addr[63:3] == ExitAddr[63:3]) & (aw.atop == 0)`.
  - If the FIFO is full, drop the entry and set `overflow_o`.
- **W tracking**
  - A beat counter marks the first beat of each burst.
  - On the first beat, the monitor samples `first_data` and `first_ok = (strb[3:0]==4'hF) & data[0]`.
  - The FIFO pops on the handshake of a beat with `w.last`.
- **W-ahead**
  - If a first beat arrives while the FIFO is empty, hold its data in a single-burst register (`wa_valid`), and pair it with the next pushed AW.
  - If a second burst starts while `wa_valid` is still set, set `overflow_o` and discard that burst.
- **Match**
  - When the burst completes (pop) and `hit & first_ok`, capture `code=data[31:1]` and `id`, then move to WAIT_B.
- **State machine**
  - **IDLE**: go to WAIT_B on a match.
  - **WAIT_B**
    - On a B handshake with `b.id==id` and `resp==OKAY`, go to DONE.
    - On a matching B handshake with a non-OKAY `resp`, set `exit_err_o` and return to IDLE.
    - A B handshake with a non-matching ID does nothing.
  - **DONE**: terminal until reset. All further traffic is ignored.
  - A match arriving while in WAIT_B or DONE is ignored (first exit wins).
- Writes of 0, or with `data[0]==0`, to the mailbox are not exits (riscv-tests `tohost` convention).

## Timing
- Every output resets to 0; all state is cleared on reset, including mid-burst.
- Bypass cases:
  - An AW handshake and the first W beat in the same cycle with an empty FIFO pair directly, without using the W-ahead register.
  - A single-beat burst whose AW handshake and W handshake land in the same cycle counts as push+pop.
- The match is registered: WAIT_B is entered the cycle after the `w.last` handshake.
- A B handshake in that same `w.last` cycle cannot belong to the burst, because AXI requires B after the last W.
- `exit_valid_o`, `exit_code_o` and `exit_id_o` rise 1 cycle after the qualifying B handshake and stay stable until reset.
- FIFO: push and pop in the same cycle while full is legal; the pop takes effect first and there is no overflow.
- The beat counter is 8-bit, which matches `axi_pkg::len_t`; it resets to 0 after each `last`.

## Structure
- Add to `culsans_pkg`:
  - `exit_aw_entry_t` (`id_slv_t id; logic hit`).
  - `localparam ExitAwDepth = 4`.
- Add an `exit_state_e` enum (IDLE/WAIT_B/DONE) in the same package.
- Sub-module: `fifo_v3` (common_cells), `DEPTH=AwDepth`, `dtype=exit_aw_entry_t`, `FALL_THROUGH=1'b1`, so that the same-cycle AW+W bypass works.
- The W-ahead register, beat counter and FSM are local to this module.

## Test plan
- **Basic exit:** AW `0x8000_0000` id 3 len 0, W `data=0x0000_0000_0000_0001` strb `0xFF`, B OKAY id 3 → `exit_valid_o=1`, `exit_code_o=0`, `exit_id_o=3`, 1 cycle after B.
- **Fail code with W before AW:** W `data=0x2B` arrives 5 cycles before AW to `exitAddr` → after B OKAY, `exit_code_o=0x15` and `overflow_o=0`.
- **Interleaved traffic:**
  - AW to `0x8000_1000` (len 3) is outstanding with AW to `exitAddr` queued behind it.
  - B responses return for the other ID first, then for the mailbox ID.
  - → Exit only after the mailbox ID's B; code taken from the second burst's beat 0.
- **Non-exit and error:**
  - Mailbox write `data=0x2` → no exit.
  - Mailbox write `data=0x3` with B `SLVERR` → `exit_err_o=1`, `exit_valid_o=0`.
  - A following `data=0x1` write with OKAY → exit with code 0.
- **Overflow:** 5 AWs without W (`AwDepth=4`) → `overflow_o=1` on the 5th handshake.
- **Reset:** assert `rst_ni` during WAIT_B → all outputs 0, state IDLE.

Source files
------------

// File: rtl/culsans_pkg.sv
// Shared types for the culsans SoC slice: slave-side AXI channel structs plus
// the exit-monitor entry, state enum and default depth.
package culsans_pkg;

    localparam int unsigned IdWidthSlave = 4;
    localparam logic [63:0] exitAddr     = 64'h0000_0000_8000_0000;
    localparam int unsigned ExitAwDepth  = 4;
    localparam logic [1:0]  RespOkay     = 2'b00;

    typedef logic [IdWidthSlave-1:0] id_slv_t;

    typedef struct packed {
        id_slv_t     id;
        logic [63:0] addr;
        logic [7:0]  len;
        logic [5:0]  atop;
    } aw_chan_slv_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
    } w_chan_t;

    typedef struct packed {
        id_slv_t    id;
        logic [1:0] resp;
    } b_chan_slv_t;

    typedef struct packed {
        aw_chan_slv_t aw;
        logic         aw_valid;
        w_chan_t      w;
        logic         w_valid;
        logic         b_ready;
    } req_slv_t;

    typedef struct packed {
        logic        aw_ready;
        logic        w_ready;
        b_chan_slv_t b;
        logic        b_valid;
    } resp_slv_t;

    typedef struct packed {
        id_slv_t id;
        logic    hit;
    } exit_aw_entry_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_B = 2'd1,
        DONE   = 2'd2
    } exit_state_e;

endpackage

// File: rtl/fifo_v3.sv
// Small synchronous FIFO. With FALL_THROUGH an entry pushed into an empty FIFO
// is visible on data_o in the same cycle and can be popped straight away.
module fifo_v3 #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DEPTH        = 8,
    parameter type         dtype        = logic
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic flush_i,
    output logic full_o,
    output logic empty_o,
    input  dtype data_i,
    input  logic push_i,
    output dtype data_o,
    input  logic pop_i
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    dtype            mem_q [DEPTH];
    logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0] cnt_q;
    logic            stored_empty, bypass, do_pop, do_push;

    assign stored_empty = (cnt_q == '0);
    assign bypass       = FALL_THROUGH && stored_empty && push_i && pop_i;
    assign full_o       = (cnt_q == CntW'(DEPTH));
    assign empty_o      = stored_empty && !(FALL_THROUGH && push_i);
    assign data_o       = (FALL_THROUGH && stored_empty) ? data_i : mem_q[rd_ptr_q];
    assign do_pop       = pop_i && !stored_empty;
    // A pop frees the slot first, so push-while-full is accepted alongside it.
    assign do_push      = push_i && (!full_o || do_pop) && !bypass;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            cnt_q <= cnt_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/culsans_exit_monitor.sv
// Passive write-channel monitor that detects the test-exit mailbox store and
// reports its code, ID and response status.
module culsans_exit_monitor
    import culsans_pkg::*;
#(
    parameter logic [63:0] ExitAddr = culsans_pkg::exitAddr,
    parameter int unsigned AwDepth  = culsans_pkg::ExitAwDepth,
    parameter type         req_t    = culsans_pkg::req_slv_t,
    parameter type         resp_t   = culsans_pkg::resp_slv_t
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  req_t                    axi_req_i,
    input  resp_t                   axi_resp_i,
    output logic                    exit_valid_o,
    output logic [30:0]             exit_code_o,
    output logic [IdWidthSlave-1:0] exit_id_o,
    output logic                    exit_err_o,
    output logic                    overflow_o,
    output exit_state_e             state_o
);

    logic aw_hs, w_hs, w_last_hs, b_hs, aw_hit, w_ok_now;
    logic first_beat, cur_disc, new_unpaired, unpaired_now, wa_pair;
    logic push_req, pop, fifo_full, fifo_empty, match_fifo, match_wa;
    logic burst_ok;
    logic [30:0] burst_code;
    exit_aw_entry_t push_entry, fifo_out;

    logic [7:0]  beat_q, beat_d;
    logic [30:0] first_code_q, first_code_d;
    logic        first_ok_q, first_ok_d;
    logic        disc_q, disc_d;
    logic        wa_valid_q, wa_valid_d;
    logic        wa_done_q, wa_done_d;
    logic        ovf_q, ovf_d;

    exit_state_e             state_q, state_d;
    logic [30:0]             code_q, code_d;
    logic [IdWidthSlave-1:0] id_q, id_d;
    logic                    err_q, err_d;

    logic unused_bits;
    assign unused_bits = ^{axi_req_i.aw.len, axi_req_i.aw.addr[2:0],
                           axi_req_i.w.data[63:32], axi_req_i.w.strb[7:4]};

    assign aw_hs     = axi_req_i.aw_valid && axi_resp_i.aw_ready;
    assign w_hs      = axi_req_i.w_valid && axi_resp_i.w_ready;
    assign w_last_hs = w_hs && axi_req_i.w.last;
    assign b_hs      = axi_resp_i.b_valid && axi_req_i.b_ready;

    assign aw_hit   = (axi_req_i.aw.addr[63:3] == ExitAddr[63:3]) && (axi_req_i.aw.atop == '0);
    assign w_ok_now = (axi_req_i.w.strb[3:0] == 4'hF) && axi_req_i.w.data[0];

    assign push_entry.id  = axi_req_i.aw.id;
    assign push_entry.hit = aw_hit;

    assign first_beat = w_hs && (beat_q == 8'd0);
    assign cur_disc   = first_beat ? wa_valid_q : disc_q;
    assign wa_pair    = wa_valid_q && aw_hs;
    // A finished W-ahead burst is matched against its AW directly, never queued.
    assign push_req   = aw_hs && !(wa_pair && wa_done_q);

    assign new_unpaired = first_beat && !wa_valid_q && fifo_empty && !aw_hs;
    assign unpaired_now = new_unpaired ||
                          (wa_valid_q && !wa_done_q && !first_beat && !aw_hs);
    assign pop          = w_last_hs && !cur_disc && !unpaired_now;

    assign burst_code = first_beat ? axi_req_i.w.data[31:1] : first_code_q;
    assign burst_ok   = first_beat ? w_ok_now : first_ok_q;
    assign match_fifo = pop && !fifo_empty && fifo_out.hit && burst_ok;
    assign match_wa   = wa_pair && wa_done_q && aw_hit && first_ok_q;

    fifo_v3 #(
        .FALL_THROUGH (1'b1),
        .DEPTH        (AwDepth),
        .dtype        (exit_aw_entry_t)
    ) i_aw_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (1'b0),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .data_i  (push_entry),
        .push_i  (push_req),
        .data_o  (fifo_out),
        .pop_i   (pop)
    );

    always_comb begin
        beat_d       = beat_q;
        first_code_d = first_code_q;
        first_ok_d   = first_ok_q;
        disc_d       = disc_q;
        wa_valid_d   = wa_valid_q;
        wa_done_d    = wa_done_q;
        ovf_d        = ovf_q;
        if (w_hs) beat_d = axi_req_i.w.last ? 8'd0 : beat_q + 8'd1;
        if (first_beat && !cur_disc) begin
            first_code_d = axi_req_i.w.data[31:1];
            first_ok_d   = w_ok_now;
        end
        if (first_beat && wa_valid_q && !axi_req_i.w.last) disc_d = 1'b1;
        else if (w_last_hs)                                 disc_d = 1'b0;
        if (wa_pair) begin
            wa_valid_d = 1'b0;
            wa_done_d  = 1'b0;
        end else begin
            if (new_unpaired)              wa_valid_d = 1'b1;
            if (w_last_hs && unpaired_now) wa_done_d  = 1'b1;
        end
        if (state_q != DONE) begin
            if ((push_req && fifo_full && !pop) || (first_beat && wa_valid_q)) ovf_d = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        id_d    = id_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (match_fifo) begin
                    state_d = WAIT_B;
                    code_d  = burst_code;
                    id_d    = fifo_out.id;
                end else if (match_wa) begin
                    state_d = WAIT_B;
                    code_d  = first_code_q;
                    id_d    = axi_req_i.aw.id;
                end
            end
            WAIT_B: begin
                if (b_hs && (axi_resp_i.b.id == id_q)) begin
                    if (axi_resp_i.b.resp == RespOkay) begin
                        state_d = DONE;
                    end else begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            beat_q       <= '0;
            first_code_q <= '0;
            first_ok_q   <= 1'b0;
            disc_q       <= 1'b0;
            wa_valid_q   <= 1'b0;
            wa_done_q    <= 1'b0;
            ovf_q        <= 1'b0;
            state_q      <= IDLE;
            code_q       <= '0;
            id_q         <= '0;
            err_q        <= 1'b0;
        end else begin
            beat_q       <= beat_d;
            first_code_q <= first_code_d;
            first_ok_q   <= first_ok_d;
            disc_q       <= disc_d;
            wa_valid_q   <= wa_valid_d;
            wa_done_q    <= wa_done_d;
            ovf_q        <= ovf_d;
            state_q      <= state_d;
            code_q       <= code_d;
            id_q         <= id_d;
            err_q        <= err_d;
        end
    end

    assign exit_valid_o = (state_q == DONE);
    assign exit_code_o  = exit_valid_o ? code_q : '0;
    assign exit_id_o    = exit_valid_o ? id_q : '0;
    assign exit_err_o   = err_q;
    assign overflow_o   = ovf_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_culsans_exit_monitor.sv
// Directed bench for culsans_exit_monitor: a vector table of single-write
// mailbox cases followed by hand-written multi-cycle sequences.
module tb_culsans_exit_monitor;
    import culsans_pkg::*;

    localparam logic [63:0] OtherAddr = 64'h0000_0000_9000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    req_slv_t  req;
    resp_slv_t rsp;
    logic                    exit_valid, exit_err, overflow;
    logic [30:0]             exit_code;
    logic [IdWidthSlave-1:0] exit_id;
    exit_state_e             state;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    culsans_exit_monitor dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .axi_req_i    (req),
        .axi_resp_i   (rsp),
        .exit_valid_o (exit_valid),
        .exit_code_o  (exit_code),
        .exit_id_o    (exit_id),
        .exit_err_o   (exit_err),
        .overflow_o   (overflow),
        .state_o      (state)
    );

    typedef struct {
        logic [63:0] addr;
        logic [5:0]  atop;
        logic [63:0] data;
        logic [7:0]  strb;
        logic [1:0]  bresp;
        logic        exp_valid;
        logic        exp_err;
        logic [30:0] exp_code;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        req.aw_valid = 1'b0;
        req.w_valid  = 1'b0;
        rsp.b_valid  = 1'b0;
    endtask

    task automatic set_aw(input logic [3:0] id, input logic [63:0] addr,
                          input logic [7:0] len, input logic [5:0] atop);
        req.aw.id   = id;
        req.aw.addr = addr;
        req.aw.len  = len;
        req.aw.atop = atop;
        req.aw_valid = 1'b1;
    endtask

    task automatic set_w(input logic [63:0] data, input logic [7:0] strb, input logic last);
        req.w.data  = data;
        req.w.strb  = strb;
        req.w.last  = last;
        req.w_valid = 1'b1;
    endtask

    task automatic set_b(input logic [3:0] id, input logic [1:0] resp);
        rsp.b.id    = id;
        rsp.b.resp  = resp;
        rsp.b_valid = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic single_write(input logic [3:0] id, input logic [63:0] data);
        set_aw(id, exitAddr, 8'd0, 6'd0);
        step();
        set_w(data, 8'hFF, 1'b1);
        step();
    endtask

    initial begin
        req = '0;
        rsp = '0;
        rsp.aw_ready = 1'b1;
        rsp.w_ready  = 1'b1;
        req.b_ready  = 1'b1;

        vecs[0]  = '{exitAddr,          6'd0,  64'h1,           8'hFF, 2'b00, 1'b1, 1'b0, 31'h0};
        vecs[1]  = '{exitAddr,          6'd0,  64'h2B,          8'hFF, 2'b00, 1'b1, 1'b0, 31'h15};
        vecs[2]  = '{exitAddr,          6'd0,  64'h2,           8'hFF, 2'b00, 1'b0, 1'b0, 31'h0};
        vecs[3]  = '{exitAddr,          6'd0,  64'h0,           8'hFF, 2'b00, 1'b0, 1'b0, 31'h0};
        vecs[4]  = '{exitAddr + 64'h8,  6'd0,  64'h1,           8'hFF, 2'b00, 1'b0, 1'b0, 31'h0};
        vecs[5]  = '{exitAddr + 64'h4,  6'd0,  64'h7,           8'hFF, 2'b00, 1'b1, 1'b0, 31'h3};
        vecs[6]  = '{exitAddr,          6'h20, 64'h1,           8'hFF, 2'b00, 1'b0, 1'b0, 31'h0};
        vecs[7]  = '{exitAddr,          6'd0,  64'h1,           8'h07, 2'b00, 1'b0, 1'b0, 31'h0};
        vecs[8]  = '{exitAddr,          6'd0,  64'hFFFF_FFFF,   8'hFF, 2'b00, 1'b1, 1'b0, 31'h7FFF_FFFF};
        vecs[9]  = '{exitAddr,          6'd0,  64'h3,           8'hFF, 2'b10, 1'b0, 1'b1, 31'h0};
        vecs[10] = '{exitAddr,          6'd0,  64'h1_0000_0003, 8'hFF, 2'b00, 1'b1, 1'b0, 31'h1};
        vecs[11] = '{exitAddr,          6'd0,  64'h5,           8'hFF, 2'b11, 1'b0, 1'b1, 31'h0};
        vecs[12] = '{exitAddr,          6'd0,  64'h9,           8'h0F, 2'b00, 1'b1, 1'b0, 31'h4};

        do_reset();
        check("rst_valid", 64'(exit_valid), 64'd0);
        check("rst_code",  64'(exit_code),  64'd0);
        check("rst_id",    64'(exit_id),    64'd0);
        check("rst_err",   64'(exit_err),   64'd0);
        check("rst_ovf",   64'(overflow),   64'd0);
        check("rst_state", 64'(state),      64'(IDLE));

        for (int i = 0; i < 13; i++) begin
            do_reset();
            set_aw(4'd5, vecs[i].addr, 8'd0, vecs[i].atop);
            step();
            set_w(vecs[i].data, vecs[i].strb, 1'b1);
            step();
            check($sformatf("v%0d_state", i), 64'(state),
                  (vecs[i].exp_valid || vecs[i].exp_err) ? 64'(WAIT_B) : 64'(IDLE));
            set_b(4'd5, vecs[i].bresp);
            step();
            check($sformatf("v%0d_valid", i), 64'(exit_valid), 64'(vecs[i].exp_valid));
            check($sformatf("v%0d_err", i),   64'(exit_err),   64'(vecs[i].exp_err));
            check($sformatf("v%0d_code", i),  64'(exit_code),  64'(vecs[i].exp_code));
            check($sformatf("v%0d_id", i),    64'(exit_id),    vecs[i].exp_valid ? 64'd5 : 64'd0);
        end

        // Basic exit, stray B with other ID, then DONE ignores a later exit.
        do_reset();
        single_write(4'd3, 64'h1);
        set_b(4'd4, 2'b00);
        step();
        check("basic_other_b", 64'(exit_valid), 64'd0);
        set_b(4'd3, 2'b00);
        step();
        check("basic_valid", 64'(exit_valid), 64'd1);
        check("basic_id",    64'(exit_id),    64'd3);
        check("basic_code",  64'(exit_code),  64'd0);
        single_write(4'd7, 64'h2B);
        set_b(4'd7, 2'b00);
        step();
        check("done_code", 64'(exit_code), 64'd0);
        check("done_id",   64'(exit_id),   64'd3);

        // W arrives five cycles ahead of its AW.
        do_reset();
        set_w(64'h2B, 8'hFF, 1'b1);
        step();
        for (int k = 0; k < 4; k++) step();
        set_aw(4'd2, exitAddr, 8'd0, 6'd0);
        step();
        check("wa_state", 64'(state), 64'(WAIT_B));
        set_b(4'd2, 2'b00);
        step();
        check("wa_valid", 64'(exit_valid), 64'd1);
        check("wa_code",  64'(exit_code),  64'h15);
        check("wa_ovf",   64'(overflow),   64'd0);

        // Interleaved: a non-mailbox burst is ahead of the mailbox burst.
        do_reset();
        set_aw(4'd1, 64'h8000_1000, 8'd3, 6'd0);
        step();
        set_aw(4'd2, exitAddr, 8'd1, 6'd0);
        step();
        set_w(64'h77, 8'hFF, 1'b0); step();
        set_w(64'h01, 8'hFF, 1'b0); step();
        set_w(64'h01, 8'hFF, 1'b0); step();
        set_w(64'h01, 8'hFF, 1'b1); step();
        check("il_state1", 64'(state), 64'(IDLE));
        set_w(64'h0B, 8'hFF, 1'b0); step();
        set_w(64'h41, 8'hFF, 1'b1); step();
        check("il_state2", 64'(state), 64'(WAIT_B));
        set_b(4'd1, 2'b00);
        step();
        check("il_b1_valid", 64'(exit_valid), 64'd0);
        set_b(4'd2, 2'b00);
        step();
        check("il_valid", 64'(exit_valid), 64'd1);
        check("il_code",  64'(exit_code),  64'h5);
        check("il_id",    64'(exit_id),    64'd2);

        // Non-exit, then error response, then a good exit.
        do_reset();
        single_write(4'd1, 64'h2);
        set_b(4'd1, 2'b00);
        step();
        check("ne_valid", 64'(exit_valid), 64'd0);
        single_write(4'd1, 64'h3);
        set_b(4'd1, 2'b10);
        step();
        check("er_err",   64'(exit_err),   64'd1);
        check("er_valid", 64'(exit_valid), 64'd0);
        check("er_state", 64'(state),      64'(IDLE));
        single_write(4'd1, 64'h1);
        set_b(4'd1, 2'b00);
        step();
        check("rt_valid", 64'(exit_valid), 64'd1);
        check("rt_code",  64'(exit_code),  64'd0);
        check("rt_err",   64'(exit_err),   64'd1);

        // Five AWs without W into a four-deep tracker.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            set_aw(4'(k), OtherAddr, 8'd0, 6'd0);
            step();
        end
        check("ovf_4", 64'(overflow), 64'd0);
        set_aw(4'd4, OtherAddr, 8'd0, 6'd0);
        step();
        check("ovf_5", 64'(overflow), 64'd1);

        // Push while full together with a pop is accepted.
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            set_aw(4'(k), OtherAddr, 8'd0, 6'd0);
            step();
        end
        set_aw(4'd6, exitAddr, 8'd0, 6'd0);
        set_w(64'h5, 8'hFF, 1'b1);
        step();
        check("fp_ovf", 64'(overflow), 64'd0);
        for (int k = 0; k < 3; k++) begin
            set_w(64'h5, 8'hFF, 1'b1);
            step();
        end
        check("fp_state1", 64'(state), 64'(IDLE));
        set_w(64'h9, 8'hFF, 1'b1);
        step();
        check("fp_state2", 64'(state), 64'(WAIT_B));
        set_b(4'd6, 2'b00);
        step();
        check("fp_valid", 64'(exit_valid), 64'd1);
        check("fp_code",  64'(exit_code),  64'h4);
        check("fp_id",    64'(exit_id),    64'd6);

        // Same-cycle AW and W with an empty tracker.
        do_reset();
        set_aw(4'd2, exitAddr, 8'd0, 6'd0);
        set_w(64'hD, 8'hFF, 1'b1);
        step();
        check("by_state", 64'(state), 64'(WAIT_B));
        set_b(4'd2, 2'b00);
        step();
        check("by_code", 64'(exit_code), 64'h6);
        check("by_ovf",  64'(overflow),  64'd0);

        // Second W-ahead burst overflows; the first still pairs with the AW.
        do_reset();
        set_w(64'h1, 8'hFF, 1'b1); step();
        set_w(64'h1, 8'hFF, 1'b1); step();
        check("w2_ovf", 64'(overflow), 64'd1);
        set_aw(4'd1, exitAddr, 8'd0, 6'd0);
        step();
        check("w2_state", 64'(state), 64'(WAIT_B));

        // Asynchronous reset while in WAIT_B.
        rst_n = 1'b0;
        #1;
        check("ar_state", 64'(state),      64'(IDLE));
        check("ar_ovf",   64'(overflow),   64'd0);
        check("ar_valid", 64'(exit_valid), 64'd0);
        step();
        rst_n = 1'b1;
        step();

        // Reset in the middle of a burst restarts the beat counter.
        set_aw(4'd3, exitAddr, 8'd1, 6'd0);
        set_w(64'h0, 8'hFF, 1'b0);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        single_write(4'd3, 64'h1);
        check("mb_state", 64'(state), 64'(WAIT_B));
        set_b(4'd3, 2'b00);
        step();
        check("mb_valid", 64'(exit_valid), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
